pll_reset_sequencer: RTL and testbench

//   Consumer side of the USB PLL: turns the PLL's raw asynchronous LOCK output into a

---
 rtl/pll_reset_sequencer_pkg.sv | 18 +
 rtl/pll_reset_sequencer_sync_ff.sv | 36 +++
 rtl/pll_reset_sequencer.sv | 130 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encodings used by the
// RTL, the debug register map and the testbench.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } state_t;

  // Counter width able to hold n itself, so no counter can wrap.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_ff.sv
// Multi-stage synchronizer that brings the asynchronous PLL lock into the clk
// domain; all stages clear to 0 while reset_n is low.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;
  logic [STAGES-1:0] sync_next;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_next[gi] = d;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns the raw PLL lock into a synchronously released USB-domain reset and a
// ready flag, with lock qualification, hold-off, glitch filtering and loss logging.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int LOSS_FILTER_CYCLES = 4,
  parameter int COUNT_WIDTH        = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  input  logic                   fault_clear,
  output logic                   usb_reset,
  output logic                   ready,
  output logic                   lock_lost,
  output logic [COUNT_WIDTH-1:0] loss_count,
  output logic [2:0]             state
);

  localparam int STAB_W = cnt_width(LOCK_STABLE_CYCLES);
  localparam int HOLD_W = cnt_width(RESET_HOLD_CYCLES);
  localparam int FILT_W = cnt_width(LOSS_FILTER_CYCLES);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOSS_FILTER_CYCLES - 1);

  logic lock_s;

  state_t            state_reg, state_next;
  logic [STAB_W-1:0] stab_cnt_reg, stab_cnt_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [FILT_W-1:0] filt_cnt_reg, filt_cnt_next;
  logic              loss_event;
  logic              usb_reset_reg;
  logic              ready_reg;
  logic              lock_lost_reg;
  logic [COUNT_WIDTH-1:0] loss_count_reg;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_s)
  );

  // Counters default to zero, so each one is cleared whenever its state is left
  // or its qualifying condition breaks.
  always_comb begin
    state_next    = state_reg;
    stab_cnt_next = '0;
    hold_cnt_next = '0;
    filt_cnt_next = '0;
    loss_event    = 1'b0;
    case (state_reg)
      ST_IDLE: state_next = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          if (stab_cnt_reg == STAB_LAST) begin
            state_next = ST_HOLD;
          end else begin
            stab_cnt_next = stab_cnt_reg + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next = ST_RUN;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          if (filt_cnt_reg == FILT_LAST) begin
            state_next = ST_LOST;
            loss_event = 1'b1;
          end else begin
            filt_cnt_next = filt_cnt_reg + 1'b1;
          end
        end
      end
      ST_LOST: state_next = ST_WAIT_LOCK;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs load from next-state so they change on the same edge as state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      stab_cnt_reg   <= '0;
      hold_cnt_reg   <= '0;
      filt_cnt_reg   <= '0;
      usb_reset_reg  <= 1'b1;
      ready_reg      <= 1'b0;
      lock_lost_reg  <= 1'b0;
      loss_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      stab_cnt_reg  <= stab_cnt_next;
      hold_cnt_reg  <= hold_cnt_next;
      filt_cnt_reg  <= filt_cnt_next;
      usb_reset_reg <= (state_next != ST_RUN);
      ready_reg     <= (state_next == ST_RUN);
      if (loss_event) begin
        lock_lost_reg <= 1'b1;
      end else if (fault_clear) begin
        lock_lost_reg <= 1'b0;
      end
      if (loss_event && (loss_count_reg != '1)) begin
        loss_count_reg <= loss_count_reg + 1'b1;
      end
    end
  end

  assign usb_reset  = usb_reset_reg;
  assign ready      = ready_reg;
  assign lock_lost  = lock_lost_reg;
  assign loss_count = loss_count_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues each expected output change with the edge
// it must appear on; a monitor compares every observed change against it.
module tb_pll_reset_sequencer;
  import pll_reset_sequencer_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       fault_clear;
  logic       usb_reset;
  logic       ready;
  logic       lock_lost;
  logic [1:0] loss_count;
  logic [2:0] state;

  pll_reset_sequencer #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (8),
    .RESET_HOLD_CYCLES  (4),
    .LOSS_FILTER_CYCLES (3),
    .COUNT_WIDTH        (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .fault_clear (fault_clear),
    .usb_reset   (usb_reset),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .loss_count  (loss_count),
    .state       (state)
  );

  typedef struct packed {
    logic [31:0] at;
    logic [7:0]  val;
  } ev_t;

  ev_t exp_q[$];
  int  edge_cnt = 0;
  int  checks   = 0;
  int  passes   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  task automatic expect_ev(input int at, input state_t st, input logic ur,
                           input logic rdy, input logic ll, input logic [1:0] lc);
    ev_t e;
    e.at  = 32'(at);
    e.val = {st, ur, rdy, ll, lc};
    exp_q.push_back(e);
  endtask

  task automatic wait_edge(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  // Monitor: any change of the output tuple is one transaction.
  initial begin
    logic [7:0] last;
    logic [7:0] cur;
    ev_t        e;
    last = 8'bx;
    forever begin
      @(negedge clk);
      cur = {state, usb_reset, ready, lock_lost, loss_count};
      if (cur !== last) begin
        last = cur;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change edge=%0d got st=%0d ur=%b rdy=%b ll=%b lc=%0d required none",
                   edge_cnt, cur[7:5], cur[4], cur[3], cur[2], cur[1:0]);
        end else begin
          e = exp_q.pop_front();
          if ((e.at == edge_cnt) && (e.val === cur)) begin
            passes++;
            $display("ok edge=%0d st=%0d usb_reset=%b ready=%b lock_lost=%b loss_count=%0d",
                     edge_cnt, cur[7:5], cur[4], cur[3], cur[2], cur[1:0]);
          end else begin
            $display("FAIL event got edge=%0d st=%0d ur=%b rdy=%b ll=%b lc=%0d required edge=%0d st=%0d ur=%b rdy=%b ll=%b lc=%0d",
                     edge_cnt, cur[7:5], cur[4], cur[3], cur[2], cur[1:0],
                     e.at, e.val[7:5], e.val[4], e.val[3], e.val[2], e.val[1:0]);
          end
        end
      end
    end
  end

  initial begin
    int t;
    reset_n     = 1'b0;
    pll_locked  = 1'b0;
    fault_clear = 1'b0;
    expect_ev(1, ST_IDLE, 1'b1, 1'b0, 1'b0, 2'd0);
    wait_edge(3);

    // Lock present at reset release: run after 2+8+4 edges.
    t = edge_cnt;
    expect_ev(t + 1,  ST_WAIT_LOCK, 1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(t + 10, ST_HOLD,      1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(t + 14, ST_RUN,       1'b0, 1'b1, 1'b0, 2'd0);
    reset_n    = 1'b1;
    pll_locked = 1'b1;
    wait_edge(t + 16);

    // Two-cycle low pulse in RUN is filtered out.
    t = edge_cnt;
    pll_locked = 1'b0;
    wait_edge(t + 2);
    pll_locked = 1'b1;
    wait_edge(t + 8);

    // First real loss, then recovery.
    t = edge_cnt;
    pll_locked = 1'b0;
    expect_ev(t + 5,  ST_LOST,      1'b1, 1'b0, 1'b1, 2'd1);
    expect_ev(t + 6,  ST_WAIT_LOCK, 1'b1, 1'b0, 1'b1, 2'd1);
    wait_edge(t + 4);
    pll_locked = 1'b1;
    expect_ev(t + 14, ST_HOLD,      1'b1, 1'b0, 1'b1, 2'd1);
    expect_ev(t + 18, ST_RUN,       1'b0, 1'b1, 1'b1, 2'd1);
    wait_edge(t + 20);

    // Second loss; during relock a one-cycle drop after 6 high samples restarts qualification.
    t = edge_cnt;
    pll_locked = 1'b0;
    expect_ev(t + 5,  ST_LOST,      1'b1, 1'b0, 1'b1, 2'd2);
    expect_ev(t + 6,  ST_WAIT_LOCK, 1'b1, 1'b0, 1'b1, 2'd2);
    wait_edge(t + 4);
    pll_locked = 1'b1;
    wait_edge(t + 10);
    pll_locked = 1'b0;
    wait_edge(t + 11);
    pll_locked = 1'b1;
    expect_ev(t + 21, ST_HOLD,      1'b1, 1'b0, 1'b1, 2'd2);
    expect_ev(t + 25, ST_RUN,       1'b0, 1'b1, 1'b1, 2'd2);
    wait_edge(t + 27);

    // Third loss reaches the saturation value.
    t = edge_cnt;
    pll_locked = 1'b0;
    expect_ev(t + 5,  ST_LOST,      1'b1, 1'b0, 1'b1, 2'd3);
    expect_ev(t + 6,  ST_WAIT_LOCK, 1'b1, 1'b0, 1'b1, 2'd3);
    wait_edge(t + 4);
    pll_locked = 1'b1;
    expect_ev(t + 14, ST_HOLD,      1'b1, 1'b0, 1'b1, 2'd3);
    expect_ev(t + 18, ST_RUN,       1'b0, 1'b1, 1'b1, 2'd3);
    wait_edge(t + 20);

    // Plain fault_clear pulse.
    t = edge_cnt;
    expect_ev(t + 1, ST_RUN, 1'b0, 1'b1, 1'b0, 2'd3);
    fault_clear = 1'b1;
    wait_edge(t + 1);
    fault_clear = 1'b0;
    wait_edge(t + 3);

    // Fourth loss with fault_clear on the same edge: set wins, count stays saturated.
    t = edge_cnt;
    pll_locked = 1'b0;
    expect_ev(t + 5,  ST_LOST,      1'b1, 1'b0, 1'b1, 2'd3);
    expect_ev(t + 6,  ST_WAIT_LOCK, 1'b1, 1'b0, 1'b1, 2'd3);
    wait_edge(t + 4);
    pll_locked  = 1'b1;
    fault_clear = 1'b1;
    wait_edge(t + 5);
    fault_clear = 1'b0;
    expect_ev(t + 14, ST_HOLD,      1'b1, 1'b0, 1'b1, 2'd3);
    expect_ev(t + 18, ST_RUN,       1'b0, 1'b1, 1'b1, 2'd3);
    wait_edge(t + 20);

    t = edge_cnt;
    expect_ev(t + 1, ST_RUN, 1'b0, 1'b1, 1'b0, 2'd3);
    fault_clear = 1'b1;
    wait_edge(t + 1);
    fault_clear = 1'b0;
    wait_edge(t + 3);

    // Fifth loss, then reset_n mid-HOLD must clear everything without a clock edge.
    t = edge_cnt;
    pll_locked = 1'b0;
    expect_ev(t + 5,  ST_LOST,      1'b1, 1'b0, 1'b1, 2'd3);
    expect_ev(t + 6,  ST_WAIT_LOCK, 1'b1, 1'b0, 1'b1, 2'd3);
    wait_edge(t + 4);
    pll_locked = 1'b1;
    expect_ev(t + 14, ST_HOLD,      1'b1, 1'b0, 1'b1, 2'd3);
    wait_edge(t + 14);
    @(posedge clk);
    #1;
    expect_ev(edge_cnt, ST_IDLE, 1'b1, 1'b0, 1'b0, 2'd0);
    reset_n = 1'b0;
    wait_edge(edge_cnt + 3);

    // Release again and assert reset_n while in RUN.
    t = edge_cnt;
    expect_ev(t + 1,  ST_WAIT_LOCK, 1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(t + 10, ST_HOLD,      1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(t + 14, ST_RUN,       1'b0, 1'b1, 1'b0, 2'd0);
    reset_n = 1'b1;
    wait_edge(t + 16);
    @(posedge clk);
    #1;
    expect_ev(edge_cnt, ST_IDLE, 1'b1, 1'b0, 1'b0, 2'd0);
    reset_n = 1'b0;
    wait_edge(edge_cnt + 3);
    #1;

    checks++;
    if (exp_q.size() == 0) begin
      passes++;
    end else begin
      $display("FAIL pending_events got %0d outstanding, next at edge=%0d required 0 outstanding",
               exp_q.size(), exp_q[0].at);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
